grad_neighbor_window: RTL and testbench

Streaming neighbourhood generator directly upstream of the gradient-magnitude stage `sum_sq_diff`. It accepts a raster-order pixel stream and buffers two image lines. For every interior pixel it presents the four 4-neighbours (top, bot, left, right) together with the centre coordinate, one valid beat per interior pixel. It has no backpressure, because the downstream pipeline is free-running.

---
 rtl/grad_neighbor_window.sv | 154 +++++++++++++++
 tb/tb_grad_neighbor_window.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/grad_neighbor_window.sv
// Purpose : raster-stream 4-neighbour generator feeding the gradient stage; holds the
//           two previous image rows and emits top/bot/left/right for every interior pixel.
// Latency : one cycle from accepting the triggering pixel (centre's lower-right diagonal)
//           to nb_valid.
// Backpr. : none, because the downstream pipeline is free-running. Input gaps pass
//           straight through as nb_valid gaps.
// Ports   : clk/rst_n; pix_valid/sof/pix in; nb_valid, top, bot, left, right,
//           out_x, out_y, frame_done out (all registered).
module grad_neighbor_window #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_valid,
  input  logic                     sof,
  input  logic [PIX_W-1:0]         pix,
  output logic                     nb_valid,
  output logic [PIX_W-1:0]         top,
  output logic [PIX_W-1:0]         bot,
  output logic [PIX_W-1:0]         left,
  output logic [PIX_W-1:0]         right,
  output logic [$clog2(IMG_W)-1:0] out_x,
  output logic [$clog2(IMG_H)-1:0] out_y,
  output logic                     frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // line1 holds row cy-1, line2 holds row cy-2 (not reset; cy >= 2 gate masks stale rows)
  logic [PIX_W-1:0] line1_q [IMG_W];
  logic [PIX_W-1:0] line2_q [IMG_W];

  logic [XW-1:0]    cx_q, cx_d, pos_x;
  logic [YW-1:0]    cy_q, cy_d, pos_y;
  logic [PIX_W-1:0] r1_rd, r2_rd;
  // Column-delayed copies of the line-buffer reads, so every buffer is read at one
  // address (the current column) per cycle.
  logic [PIX_W-1:0] r1_d1_q, r1_d1_d;   // row cy-1, column cx-1
  logic [PIX_W-1:0] r1_d2_q, r1_d2_d;   // row cy-1, column cx-2
  logic [PIX_W-1:0] r2_d1_q, r2_d1_d;   // row cy-2, column cx-1
  logic [PIX_W-1:0] prev_q,  prev_d;    // previous accepted pixel
  logic             trig;

  logic             nb_valid_q, nb_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] top_q, top_d, bot_q, bot_d, left_q, left_d, right_q, right_d;
  logic [XW-1:0]    out_x_q, out_x_d;
  logic [YW-1:0]    out_y_q, out_y_d;

  always_comb begin
    // sof re-anchors the current pixel at (0,0); it can therefore never trigger
    pos_x = sof ? '0 : cx_q;
    pos_y = sof ? '0 : cy_q;
    r1_rd = line1_q[pos_x];
    r2_rd = line2_q[pos_x];
    trig  = pix_valid && (pos_x >= X_TWO) && (pos_y >= Y_TWO);

    cx_d    = cx_q;
    cy_d    = cy_q;
    r1_d1_d = r1_d1_q;
    r1_d2_d = r1_d2_q;
    r2_d1_d = r2_d1_q;
    prev_d  = prev_q;
    if (pix_valid) begin
      if (pos_x == X_LAST) begin
        cx_d = '0;
        cy_d = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
      end else begin
        cx_d = pos_x + XW'(1);
        cy_d = pos_y;
      end
      r1_d1_d = r1_rd;
      r1_d2_d = r1_d1_q;
      r2_d1_d = r2_rd;
      prev_d  = pix;
    end

    nb_valid_d   = trig;
    frame_done_d = trig && (pos_x == X_LAST) && (pos_y == Y_LAST);
    top_d        = top_q;
    bot_d        = bot_q;
    left_d       = left_q;
    right_d      = right_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    if (trig) begin
      top_d   = r2_d1_q;
      bot_d   = prev_q;
      left_d  = r1_d2_q;
      right_d = r1_rd;
      out_x_d = pos_x - XW'(1);
      out_y_d = pos_y - YW'(1);
    end
  end

  // Row shift: the old row cy-1 value moves to line2 as the new pixel lands in line1.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line2_q[pos_x] <= r1_rd;
      line1_q[pos_x] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q         <= '0;
      cy_q         <= '0;
      r1_d1_q      <= '0;
      r1_d2_q      <= '0;
      r2_d1_q      <= '0;
      prev_q       <= '0;
      nb_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      top_q        <= '0;
      bot_q        <= '0;
      left_q       <= '0;
      right_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      r1_d1_q      <= r1_d1_d;
      r1_d2_q      <= r1_d2_d;
      r2_d1_q      <= r2_d1_d;
      prev_q       <= prev_d;
      nb_valid_q   <= nb_valid_d;
      frame_done_q <= frame_done_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      left_q       <= left_d;
      right_q      <= right_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
    end
  end

  assign nb_valid   = nb_valid_q;
  assign frame_done = frame_done_q;
  assign top        = top_q;
  assign bot        = bot_q;
  assign left       = left_q;
  assign right      = right_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;

endmodule

// File: tb/tb_grad_neighbor_window.sv
// Purpose : self-check of grad_neighbor_window on a 4x4 instance (directed scenarios)
//           and a 160x120 instance (random frame) against an image-array reference.
// Timing  : inputs change 1 time unit after each rising edge; outputs sampled there too.
module tb_grad_neighbor_window;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  logic       s_valid = 1'b0, s_sof = 1'b0;
  logic [7:0] s_pix = '0;
  logic       s_nb_valid, s_frame_done;
  logic [7:0] s_top, s_bot, s_left, s_right;
  logic [1:0] s_out_x, s_out_y;

  // 160x120 instance
  logic       l_valid = 1'b0, l_sof = 1'b0;
  logic [7:0] l_pix = '0;
  logic       l_nb_valid, l_frame_done;
  logic [7:0] l_top, l_bot, l_left, l_right;
  logic [7:0] l_out_x;
  logic [6:0] l_out_y;

  grad_neighbor_window #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_valid(s_valid), .sof(s_sof), .pix(s_pix),
    .nb_valid(s_nb_valid), .top(s_top), .bot(s_bot), .left(s_left), .right(s_right),
    .out_x(s_out_x), .out_y(s_out_y), .frame_done(s_frame_done));

  grad_neighbor_window #(.PIX_W(8), .IMG_W(160), .IMG_H(120)) dut_l (
    .clk(clk), .rst_n(rst_n), .pix_valid(l_valid), .sof(l_sof), .pix(l_pix),
    .nb_valid(l_nb_valid), .top(l_top), .bot(l_bot), .left(l_left), .right(l_right),
    .out_x(l_out_x), .out_y(l_out_y), .frame_done(l_frame_done));

  int n_asserts = 0;
  int n_fail    = 0;

  // reference model: the image as written so far, plus the bench's own raster position
  logic [7:0] img [0:119][0:159];
  int  img_w = 4, img_h = 4;
  int  mx = 0, my = 0;
  bit  big = 1'b0;
  logic [31:0] e_top = 0, e_bot = 0, e_left = 0, e_right = 0, e_x = 0, e_y = 0;
  int  beats = 0, fd_cnt = 0;
  logic [31:0] beat_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mx = 0; my = 0;
    e_top = 0; e_bot = 0; e_left = 0; e_right = 0; e_x = 0; e_y = 0;
  endtask

  // One input cycle: drive, predict, clock, compare every output.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    logic trig, fd;
    int cx, cy;
    logic        o_v, o_fd;
    logic [31:0] o_top, o_bot, o_left, o_right, o_x, o_y;
    if (big) begin
      l_valid = v; l_sof = s; l_pix = p;
      s_valid = 1'b0; s_sof = 1'b0;
    end else begin
      s_valid = v; s_sof = s; s_pix = p;
      l_valid = 1'b0; l_sof = 1'b0;
    end
    trig = 1'b0; fd = 1'b0; cx = 0; cy = 0;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      img[my][mx] = p;
      if (mx >= 2 && my >= 2) begin
        trig = 1'b1;
        cx = mx - 1; cy = my - 1;
        e_top   = 32'(img[cy-1][cx]);
        e_bot   = 32'(img[cy+1][cx]);
        e_left  = 32'(img[cy][cx-1]);
        e_right = 32'(img[cy][cx+1]);
        e_x = 32'(cx); e_y = 32'(cy);
        fd = (cx == img_w - 2) && (cy == img_h - 2);
      end
      mx++;
      if (mx == img_w) begin
        mx = 0; my++;
        if (my == img_h) my = 0;
      end
    end
    @(posedge clk); #1;
    if (big) begin
      o_v = l_nb_valid; o_fd = l_frame_done;
      o_top = 32'(l_top); o_bot = 32'(l_bot); o_left = 32'(l_left); o_right = 32'(l_right);
      o_x = 32'(l_out_x); o_y = 32'(l_out_y);
    end else begin
      o_v = s_nb_valid; o_fd = s_frame_done;
      o_top = 32'(s_top); o_bot = 32'(s_bot); o_left = 32'(s_left); o_right = 32'(s_right);
      o_x = 32'(s_out_x); o_y = 32'(s_out_y);
    end
    chk("nb_valid", 32'(o_v), 32'(trig));
    chk("frame_done", 32'(o_fd), 32'(fd));
    chk("top", o_top, e_top);
    chk("bot", o_bot, e_bot);
    chk("left", o_left, e_left);
    chk("right", o_right, e_right);
    chk("out_x", o_x, e_x);
    chk("out_y", o_y, e_y);
    if (o_v === 1'b1) begin
      beats++;
      beat_q.push_back({o_top[7:0], o_bot[7:0], o_left[7:0], o_right[7:0]});
    end
    if (o_fd === 1'b1) fd_cnt++;
  endtask

  task automatic frame(input int base, input bit with_sof, input bit gappy);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        step(1'b1, with_sof && x == 0 && y == 0, 8'(16*y + x + base));
        if (gappy) step(1'b0, 1'b0, 8'hA5);
      end
  endtask

  task automatic reset_and_check();
    logic [31:0] all_s, all_l;
    s_valid = 1'b0; s_sof = 1'b0; l_valid = 1'b0; l_sof = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      all_s = {22'd0, s_nb_valid, s_frame_done, s_out_x, s_out_y, 4'd0} |
              32'({s_top, s_bot, s_left, s_right});
      all_l = {s_nb_valid, l_nb_valid, l_frame_done, l_out_x, l_out_y, 14'd0} |
              32'({l_top, l_bot, l_left, l_right});
      chk("reset_small_outputs", all_s, 32'd0);
      chk("reset_large_outputs", all_l, 32'd0);
      repeat (3) @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic scen_begin();
    beats = 0; fd_cnt = 0; beat_q.delete();
  endtask

  task automatic check_s1_values(input string tag, input int first);
    logic [31:0] b;
    if (beat_q.size() > first + 3) begin
      b = beat_q[first];
      chk({tag, "_c11"}, b, {8'd1, 8'd33, 8'd16, 8'd18});
      b = beat_q[first + 3];
      chk({tag, "_c22"}, b, {8'd18, 8'd50, 8'd33, 8'd35});
    end else begin
      chk({tag, "_beats_present"}, 32'(beat_q.size()), 32'(first + 4));
    end
  endtask

  initial begin
    logic [31:0] b;

    // reset state
    reset_and_check();

    // 1: basic frame
    scen_begin();
    frame(0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("s1_beats", 32'(beats), 32'd4);
    chk("s1_frame_done", 32'(fd_cnt), 32'd1);
    check_s1_values("s1", 0);

    // 2: gappy input (per-cycle nb_valid check rules out back-to-back beats)
    scen_begin();
    frame(0, 1'b1, 1'b1);
    chk("s2_beats", 32'(beats), 32'd4);
    check_s1_values("s2", 0);

    // 3: back-to-back frames, second without sof
    scen_begin();
    frame(0, 1'b1, 1'b0);
    frame(128, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("s3_beats", 32'(beats), 32'd8);
    chk("s3_frame_done", 32'(fd_cnt), 32'd2);
    if (beat_q.size() > 4) begin
      b = beat_q[4];
      chk("s3_f2_top_bot", 32'(b[31:16]), 32'({8'd129, 8'd161}));
    end else chk("s3_beats_present", 32'(beat_q.size()), 32'd8);

    // 4: sof on the 7th pixel, then a full frame
    scen_begin();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(200 + i));
    frame(0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("s4_beats", 32'(beats), 32'd4);
    check_s1_values("s4", 0);

    // 5: reset after 10 pixels, fresh frame without sof
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(16*(i/4) + (i%4)));
    reset_and_check();
    scen_begin();
    frame(0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("s5_beats", 32'(beats), 32'd4);
    chk("s5_frame_done", 32'(fd_cnt), 32'd1);
    check_s1_values("s5", 0);

    // 6: default geometry, random pixels
    big = 1'b1; img_w = 160; img_h = 120;
    model_clear();
    scen_begin();
    for (int i = 0; i < 160*120; i++) step(1'b1, i == 0, 8'($urandom_range(0, 255)));
    step(1'b0, 1'b0, 8'h00);
    chk("s6_beats", 32'(beats), 32'd18644);
    chk("s6_frame_done", 32'(fd_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
